keypad_scan_ctrl: RTL



---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/keypad_col_sync.sv | 30 +++
 rtl/keypad_scan_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the 3x4 PMOD keypad scanner.
//   state_t       : scan sequencer states
//   NO_KEY, KEY_STAR, KEY_HASH : special key codes
//   ROW_B..ROW_D  : row indices; index n drives row bit n
//   KEY_MAP       : key code lookup indexed [row index][column index]
//   col_single    : 1 when exactly one column bit is set
//   col_index     : column index of a one-hot column pattern
//   key_lookup    : key code for a row index and a one-hot column pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  localparam logic [3:0] NO_KEY   = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam logic [1:0] ROW_B = 2'd0;
  localparam logic [1:0] ROW_G = 2'd1;
  localparam logic [1:0] ROW_F = 2'd2;
  localparam logic [1:0] ROW_D = 2'd3;

  // Column index 0 = C, 1 = A, 2 = E (col bit order).
  localparam logic [3:0] KEY_MAP [0:3][0:2] = '{
    '{4'h1,     4'h2, 4'h3},
    '{4'h4,     4'h5, 4'h6},
    '{4'h7,     4'h8, 4'h9},
    '{KEY_STAR, 4'h0, KEY_HASH}
  };

  function automatic logic col_single(input logic [2:0] pat);
    logic single;
    case (pat)
      3'b001, 3'b010, 3'b100: single = 1'b1;
      default:                single = 1'b0;
    endcase
    return single;
  endfunction

  function automatic logic [1:0] col_index(input logic [2:0] pat);
    logic [1:0] idx;
    case (pat)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [2:0] pat);
    return KEY_MAP[row_idx][col_index(pat)];
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync
// Two-flop synchronizer for the three asynchronous keypad column inputs.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : raw column inputs
//   q     : synchronized columns (two cycles of latency)
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] meta_r;
  logic [2:0] sync_r;

  // Synchronizer flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 3'b000;
      sync_r <= 3'b000;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Row scan sequencer, debouncer and key event reporter for the 3x4 PMOD keypad.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   scan_en   : 1 enables scanning; 0 blanks the rows and parks at row B
//   col       : column inputs (bit0 C, bit1 A, bit2 E), active-high, async
//   row       : one-hot row drive (bit0 B, bit1 G, bit2 F, bit3 D)
//   key_code  : last accepted key code
//   key_valid : level interrupt, new key pending until key_ack
//   key_ack   : one-cycle acknowledge from the MCU
//   overrun   : sticky, a key was accepted while key_valid was still set
//   key_held  : accepted key not yet released
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 22727270,
  parameter int DEBOUNCE_CNT  = 16,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun,
  output logic       key_held
);

  localparam int MAX_A   = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAX_CNT = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);

  logic [2:0]       csync;
  state_t           state_r, state_nxt;
  logic [1:0]       idx_r, idx_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [3:0]       cand_code_r, cand_code_nxt;
  logic [2:0]       cand_pat_r, cand_pat_nxt;
  logic [3:0]       row_r, key_code_r;
  logic             key_valid_r, overrun_r, key_held_r;
  logic             accept_s, release_s, repeat_s, report_s;

  keypad_col_sync u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col),
    .q     (csync)
  );

  // FSM, row index, dwell/debounce counter and candidate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SCAN;
      idx_r       <= ROW_B;
      cnt_r       <= CNT_ZERO;
      cand_code_r <= NO_KEY;
      cand_pat_r  <= 3'b000;
    end else begin
      state_r     <= state_nxt;
      idx_r       <= idx_nxt;
      cnt_r       <= cnt_nxt;
      cand_code_r <= cand_code_nxt;
      cand_pat_r  <= cand_pat_nxt;
    end
  end

  // Next-state logic: dwell on each row, debounce one key, wait for release.
  always_comb begin
    state_nxt     = state_r;
    idx_nxt       = idx_r;
    cnt_nxt       = cnt_r;
    cand_code_nxt = cand_code_r;
    cand_pat_nxt  = cand_pat_r;
    accept_s      = 1'b0;
    release_s     = 1'b0;
    if (!scan_en) begin
      state_nxt = SCAN;
      idx_nxt   = ROW_B;
      cnt_nxt   = CNT_ZERO;
    end else begin
      case (state_r)
        SCAN: begin
          if (cnt_r == SCAN_LAST) begin
            cnt_nxt = CNT_ZERO;
            if (col_single(csync)) begin
              // Row stays driven while the candidate is debounced.
              state_nxt     = DEBOUNCE;
              cand_code_nxt = key_lookup(idx_r, csync);
              cand_pat_nxt  = csync;
            end else begin
              // No key, or a multi-key/ghost pattern: move to the next row.
              idx_nxt = idx_r + 2'd1;
            end
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (csync == cand_pat_r) begin
            if (cnt_r == DB_LAST) begin
              accept_s  = 1'b1;
              state_nxt = RELEASE;
              cnt_nxt   = CNT_ZERO;
            end else begin
              cnt_nxt = cnt_r + CNT_ONE;
            end
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx_r + 2'd1;
            cnt_nxt   = CNT_ZERO;
          end
        end
        RELEASE: begin
          if (csync == 3'b000) begin
            if (cnt_r == DB_LAST) begin
              release_s = 1'b1;
              state_nxt = SCAN;
              idx_nxt   = idx_r + 2'd1;
              cnt_nxt   = CNT_ZERO;
            end else begin
              cnt_nxt = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_nxt = CNT_ZERO;
          end
        end
        default: begin
          state_nxt = SCAN;
          idx_nxt   = ROW_B;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt_r, rep_cnt_nxt;

  // Auto-repeat period counter; runs only while the key is held in RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_r <= CNT_ZERO;
    end else begin
      rep_cnt_r <= rep_cnt_nxt;
    end
  end

  // Repeat request when a full period elapses with the key still down.
  always_comb begin
    rep_cnt_nxt = CNT_ZERO;
    repeat_s    = 1'b0;
    if (scan_en && (state_r == RELEASE) && (csync != 3'b000)) begin
      if (rep_cnt_r == REP_LAST) begin
        repeat_s = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt_r + CNT_ONE;
      end
    end else begin
      rep_cnt_nxt = CNT_ZERO;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  assign report_s = accept_s | repeat_s;

  // Report registers and MCU handshake; a new report wins over a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_r  <= NO_KEY;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (report_s) begin
      key_code_r  <= cand_code_r;
      key_valid_r <= 1'b1;
      if (key_valid_r && !key_ack) begin
        overrun_r <= 1'b1;
      end
    end else if (key_ack && key_valid_r) begin
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end
  end

  // Held flag and registered row drive; rows are blanked while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_held_r <= 1'b0;
      row_r      <= 4'b0001;
    end else begin
      if (!scan_en) begin
        key_held_r <= 1'b0;
      end else if (accept_s) begin
        key_held_r <= 1'b1;
      end else if (release_s) begin
        key_held_r <= 1'b0;
      end
      row_r <= scan_en ? (4'b0001 << idx_nxt) : 4'b0000;
    end
  end

  assign row       = row_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign overrun   = overrun_r;
  assign key_held  = key_held_r;

endmodule
